bip_datapath: RTL

- Accumulator datapath and data memory of the single-cycle BIP processor.
- Sits directly downstream of the instruction-decode/control unit and consumes its signals: SelA, SelB, WrAcc, Op, WrRam, RdRam and the 11-bit operand.
- Holds the accumulator (ACC), a sign-extension unit, an add/sub ALU, a 2^NBITS_0-word data RAM, an overflow flag and a retired-instruction counter.
- A debug unit can freeze all state with i_enable and read data RAM through a side port.

---
 rtl/bip_datapath_pkg.sv | 30 +++
 rtl/bip_data_ram.sv | 32 +++
 rtl/bip_datapath.sv | 109 ++++++++++
 3 files changed

// File: rtl/bip_datapath_pkg.sv
// Shared encodings and default widths for the BIP decoder and datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bip_datapath_pkg;

    localparam int BIP_NBITS_0   = 11;  // operand / data-address width
    localparam int BIP_NBITS_D   = 16;  // data word / accumulator width
    localparam int BIP_NBITS_CNT = 32;  // retired-instruction counter width

    // Accumulator source select; SELA_HOLD keeps the current value.
    typedef enum logic [1:0] {
        SELA_MEM  = 2'b00,
        SELA_IMM  = 2'b01,
        SELA_ALU  = 2'b10,
        SELA_HOLD = 2'b11
    } sela_e;

    // ALU B-operand select.
    typedef enum logic {
        SELB_MEM = 1'b0,
        SELB_IMM = 1'b1
    } selb_e;

    // ALU operation; subtract computes ACC - B.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/bip_data_ram.sv
// Data RAM: one synchronous write port, two asynchronous read ports (datapath, debug).
// Latency: write visible to reads the cycle after the edge; reads are zero-latency.
// Backpressure: none; the caller qualifies wr_en.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (datapath read),
//        dbg_addr/dbg_data (debug read). Contents are not reset.
module bip_data_ram #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [WIDTH-1:0]     dbg_data
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational reads return the pre-edge contents during a write cycle.
    assign rd_data  = mem[rd_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/bip_datapath.sv
// BIP accumulator datapath: sign extension, add/sub ALU, ACC, data RAM, overflow flag, retire counter.
// Latency: single cycle; every enabled edge retires one instruction, RAM reads are combinational.
// Backpressure: none; i_enable = 0 freezes all state (debug stall).
// Ports: i_clock, i_reset (async, active high), i_enable, decoder controls
//        (i_SelA, i_SelB, i_WrAcc, i_Op, i_WrRam, i_RdRam, i_Operand), debug read
//        (i_DbgAddr -> o_DbgData), status (o_Acc, o_Ovf, o_RetCnt).
module bip_datapath
    import bip_datapath_pkg::*;
#(
    parameter int NBITS_0   = BIP_NBITS_0,
    parameter int NBITS_D   = BIP_NBITS_D,
    parameter int NBITS_CNT = BIP_NBITS_CNT
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [1:0]           i_SelA,
    input  logic                 i_SelB,
    input  logic                 i_WrAcc,
    input  logic                 i_Op,
    input  logic                 i_WrRam,
    input  logic                 i_RdRam,
    input  logic [NBITS_0-1:0]   i_Operand,
    input  logic [NBITS_0-1:0]   i_DbgAddr,
    output logic [NBITS_D-1:0]   o_Acc,
    output logic                 o_Ovf,
    output logic [NBITS_CNT-1:0] o_RetCnt,
    output logic [NBITS_D-1:0]   o_DbgData
);

    logic [NBITS_D-1:0]   acc;
    logic                 ovf;
    logic [NBITS_CNT-1:0] ret_cnt;

    logic [NBITS_D-1:0]   sext;
    logic [NBITS_D-1:0]   ram_rdata;
    logic [NBITS_D-1:0]   rdata;
    logic [NBITS_D-1:0]   alu_b;
    logic [NBITS_D-1:0]   alu_r;
    logic                 alu_ovf;
    logic [NBITS_D-1:0]   acc_src;

    assign sext = {{(NBITS_D-NBITS_0){i_Operand[NBITS_0-1]}}, i_Operand};

    // Read data is forced to zero when the decoder is not reading, so a
    // SelA=MEM load without RdRam clears ACC.
    assign rdata = i_RdRam ? ram_rdata : '0;

    assign alu_b = (selb_e'(i_SelB) == SELB_IMM) ? sext : rdata;

    always_comb begin
        alu_r   = acc + alu_b;
        alu_ovf = (acc[NBITS_D-1] == alu_b[NBITS_D-1]) &&
                  (alu_r[NBITS_D-1] != acc[NBITS_D-1]);
        if (op_e'(i_Op) == OP_SUB) begin
            alu_r   = acc - alu_b;
            alu_ovf = (acc[NBITS_D-1] != alu_b[NBITS_D-1]) &&
                      (alu_r[NBITS_D-1] != acc[NBITS_D-1]);
        end
    end

    always_comb begin
        acc_src = acc;
        case (sela_e'(i_SelA))
            SELA_MEM:  acc_src = rdata;
            SELA_IMM:  acc_src = sext;
            SELA_ALU:  acc_src = alu_r;
            default:   acc_src = acc;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            acc     <= '0;
            ovf     <= 1'b0;
            ret_cnt <= '0;
        end else if (i_enable) begin
            if (i_WrAcc) begin
                acc <= acc_src;
                // Flag only latches on an ALU result actually committed to ACC.
                if ((sela_e'(i_SelA) == SELA_ALU) && alu_ovf) begin
                    ovf <= 1'b1;
                end
            end
            ret_cnt <= ret_cnt + 1'b1;
        end
    end

    // RAM is written with the pre-edge ACC, so a simultaneous ACC write
    // stores the old accumulator.
    bip_data_ram #(
        .WIDTH     (NBITS_D),
        .ADDR_BITS (NBITS_0)
    ) u_ram (
        .clk      (i_clock),
        .wr_en    (i_enable && i_WrRam),
        .wr_addr  (i_Operand),
        .wr_data  (acc),
        .rd_addr  (i_Operand),
        .rd_data  (ram_rdata),
        .dbg_addr (i_DbgAddr),
        .dbg_data (o_DbgData)
    );

    assign o_Acc    = acc;
    assign o_Ovf    = ovf;
    assign o_RetCnt = ret_cnt;

endmodule
